// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM
// states, datapath select codes and the decoded-opcode field bundle.
package ctrl_pkg;

    // RV32I major opcodes understood by the control unit
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Wide enough for any memory-wait limit from 1 to 255
    localparam int WAIT_W = 8;

    // Debug-visible state numbering is part of the interface
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_type_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } alu_op_e;

    // Static per-opcode attributes; the FSM decides when they take effect
    typedef struct packed {
        logic      legal;
        logic      alu_src;
        imm_type_e imm_type;
        alu_op_e   alu_op;
        logic      is_load;
        logic      is_store;
        logic      is_branch;
        logic      is_jump;
    } op_fields_t;

endpackage

// File: rtl/opcode_field_decode.sv
// Combinational opcode -> datapath-field map, same static encoding as the
// single-cycle decoder. Unknown opcodes come back with legal = 0.
module opcode_field_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_fields_t fields
);

    // Look up the fixed field values for each supported opcode
    always_comb begin
        // NOTE: the whole struct is defaulted before the case, so no path leaves a field unassigned and no latch is inferred.
        fields = '0;
        case (opcode)
            OP_R: begin
                fields.legal  = 1'b1;
                fields.alu_op = ALU_RTYPE;
            end
            OP_I: begin
                fields.legal   = 1'b1;
                fields.alu_src = 1'b1;
                fields.alu_op  = ALU_ITYPE;
            end
            OP_LOAD: begin
                fields.legal   = 1'b1;
                fields.alu_src = 1'b1;
                fields.is_load = 1'b1;
            end
            OP_STORE: begin
                fields.legal    = 1'b1;
                fields.alu_src  = 1'b1;
                fields.imm_type = IMM_S;
                fields.is_store = 1'b1;
            end
            OP_BRANCH: begin
                fields.legal     = 1'b1;
                fields.imm_type  = IMM_B;
                fields.alu_op    = ALU_BRANCH;
                fields.is_branch = 1'b1;
            end
            OP_JAL: begin
                fields.legal    = 1'b1;
                fields.alu_src  = 1'b1;
                fields.imm_type = IMM_J;
                fields.is_jump  = 1'b1;
            end
            OP_JALR: begin
                fields.legal   = 1'b1;
                fields.alu_src = 1'b1;
                fields.is_jump = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                fields.legal    = 1'b1;
                fields.alu_src  = 1'b1;
                fields.imm_type = IMM_U;
            end
            default: fields = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB over a
// shared memory with a ready handshake, with stall, memory-wait timeout,
// illegal-opcode trap and a retired-instruction counter.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int MAX_WAIT  = 16,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    input  logic                 stall,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_sel,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 alu_src,
    output logic [1:0]           pc_src,
    output logic [2:0]           imm_type,
    output logic [1:0]           alu_op,
    output logic [2:0]           state_o,
    output logic                 illegal_instr,
    output logic                 mem_timeout,
    output logic [INSTRET_W-1:0] instret
);

    // Wait-counter value during the last cycle an access may still wait
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e               state_q;
    state_e               state_n;
    logic [6:0]           opcode_q;
    logic [6:0]           opcode_n;
    logic [WAIT_W-1:0]    wait_q;
    logic [WAIT_W-1:0]    wait_n;
    logic [INSTRET_W-1:0] instret_q;
    logic                 illegal_q;
    logic                 timeout_q;
    logic                 retire;
    logic                 set_illegal;
    logic                 set_timeout;
    logic [6:0]           decode_src;
    op_fields_t           fields;

    // In DECODE the legality check must see the freshly loaded instruction
    // register; everywhere else the latched copy drives the fields.
    assign decode_src = (state_q == ST_DECODE) ? opcode : opcode_q;

    opcode_field_decode u_decode (
        .opcode (decode_src),
        .fields (fields)
    );

    // State register, latched opcode, wait counter, retire count, sticky flags
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            opcode_q  <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            opcode_q <= opcode_n;
            wait_q   <= wait_n;
            if (retire) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next state, bookkeeping strobes and datapath controls for this state
    always_comb begin
        state_n     = state_q;
        opcode_n    = opcode_q;
        wait_n      = wait_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_sel     = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        pc_src      = PC_PLUS4;
        imm_type    = IMM_I;
        alu_op      = ALU_ADD;

        // While reset is asserted every output stays at its zero default
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read = !stall;
                    if (!stall) begin
                        if (mem_ready) begin
                            ir_write = 1'b1;
                            state_n  = ST_DECODE;
                        end else if (wait_q == WAIT_LAST) begin
                            set_timeout = 1'b1;
                            state_n     = ST_TRAP;
                        end else begin
                            wait_n = wait_q + WAIT_W'(1);
                        end
                    end
                end

                ST_DECODE: begin
                    if (!stall) begin
                        opcode_n = opcode;
                        if (fields.legal) begin
                            state_n = ST_EXECUTE;
                        end else begin
                            set_illegal = 1'b1;
                            state_n     = ST_TRAP;
                        end
                    end
                end

                ST_EXECUTE: begin
                    alu_src  = fields.alu_src;
                    imm_type = fields.imm_type;
                    alu_op   = fields.alu_op;
                    if (fields.is_branch) begin
                        pc_write = !stall;
                        pc_src   = branch_taken ? PC_BRANCH : PC_PLUS4;
                    end
                    if (!stall) begin
                        if (fields.is_branch) begin
                            retire  = 1'b1;
                            state_n = ST_FETCH;
                        end else if (fields.is_load || fields.is_store) begin
                            state_n = ST_MEM;
                        end else begin
                            state_n = ST_WB;
                        end
                    end
                end

                ST_MEM: begin
                    mem_sel   = 1'b1;
                    mem_read  = fields.is_load && !stall;
                    mem_write = fields.is_store && !stall;
                    if (!stall) begin
                        if (mem_ready) begin
                            if (fields.is_store) begin
                                pc_write = 1'b1;
                                retire   = 1'b1;
                                state_n  = ST_FETCH;
                            end else begin
                                state_n = ST_WB;
                            end
                        end else if (wait_q == WAIT_LAST) begin
                            set_timeout = 1'b1;
                            state_n     = ST_TRAP;
                        end else begin
                            wait_n = wait_q + WAIT_W'(1);
                        end
                    end
                end

                ST_WB: begin
                    reg_write  = !stall;
                    mem_to_reg = fields.is_load;
                    pc_write   = !stall;
                    pc_src     = fields.is_jump ? PC_JUMP : PC_PLUS4;
                    if (!stall) begin
                        retire  = 1'b1;
                        state_n = ST_FETCH;
                    end
                end

                ST_TRAP: begin
                    state_n = ST_TRAP;
                end

                default: begin
                    state_n = ST_TRAP;
                end
            endcase

            // A new state always starts its wait count from zero
            if (state_n != state_q) begin
                wait_n = '0;
            end
        end
    end

    assign state_o       = rst_n ? 3'(state_q) : 3'd0;
    assign instret       = rst_n ? instret_q : '0;
    assign illegal_instr = rst_n & illegal_q;
    assign mem_timeout   = rst_n & timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus a
// randomized instruction stream checked against a phase-list reference model.
module tb_multicycle_control_unit;

    localparam int MAX_WAIT_TB  = 4;
    localparam int INSTRET_W_TB = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] LEGAL_OPS [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    // Instruction phases, numbered as the debug state output reports them
    localparam int PH_F = 0;
    localparam int PH_D = 1;
    localparam int PH_E = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [6:0]              opcode;
    logic                    branch_taken;
    logic                    mem_ready;
    logic                    stall;
    logic                    pc_write;
    logic                    ir_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_sel;
    logic                    reg_write;
    logic                    mem_to_reg;
    logic                    alu_src;
    logic [1:0]              pc_src;
    logic [2:0]              imm_type;
    logic [1:0]              alu_op;
    logic [2:0]              state_o;
    logic                    illegal_instr;
    logic                    mem_timeout;
    logic [INSTRET_W_TB-1:0] instret;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [INSTRET_W_TB-1:0] exp_instret = '0;

    multicycle_control_unit #(
        .MAX_WAIT  (MAX_WAIT_TB),
        .INSTRET_W (INSTRET_W_TB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .stall         (stall),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_sel       (mem_sel),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src       (alu_src),
        .pc_src        (pc_src),
        .imm_type      (imm_type),
        .alu_op        (alu_op),
        .state_o       (state_o),
        .illegal_instr (illegal_instr),
        .mem_timeout   (mem_timeout),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic rbit();
        return ($urandom_range(1, 0) == 1);
    endfunction

    // All combinational control outputs plus the debug state, one vector
    function automatic logic [17:0] act_vec();
        return {pc_write, ir_write, mem_read, mem_write, mem_sel, reg_write, mem_to_reg,
                alu_src, pc_src, imm_type, alu_op, state_o};
    endfunction

    // {alu_src, imm_type, alu_op} of the single-cycle decoder per opcode
    function automatic logic [5:0] alu_fields(input logic [6:0] op);
        case (op)
            OP_R:             return {1'b0, 3'd0, 2'b10};
            OP_I:             return {1'b1, 3'd0, 2'b11};
            OP_LOAD:          return {1'b1, 3'd0, 2'b00};
            OP_STORE:         return {1'b1, 3'd1, 2'b00};
            OP_BRANCH:        return {1'b0, 3'd2, 2'b01};
            OP_JAL:           return {1'b1, 3'd4, 2'b00};
            OP_JALR:          return {1'b1, 3'd0, 2'b00};
            OP_LUI, OP_AUIPC: return {1'b1, 3'd3, 2'b00};
            default:          return 6'd0;
        endcase
    endfunction

    // What the datapath must see during one cycle of a given phase
    function automatic logic [17:0] exp_vec(input int ph, input logic [6:0] op,
                                            input logic tkn, input logic stl, input logic rdy);
        logic       pcw, irw, mr, mw, ms, rw, m2r;
        logic [1:0] psrc;
        logic [5:0] f;
        logic       is_ld, is_st, is_jmp;
        {pcw, irw, mr, mw, ms, rw, m2r} = 7'b0;
        psrc   = 2'b00;
        f      = 6'd0;
        is_ld  = (op == OP_LOAD);
        is_st  = (op == OP_STORE);
        is_jmp = (op == OP_JAL) || (op == OP_JALR);
        case (ph)
            PH_F: begin
                mr  = !stl;
                irw = rdy && !stl;
            end
            PH_E: begin
                f = alu_fields(op);
                if (op == OP_BRANCH) begin
                    pcw  = !stl;
                    psrc = tkn ? 2'b01 : 2'b00;
                end
            end
            PH_M: begin
                ms  = 1'b1;
                mr  = is_ld && !stl;
                mw  = is_st && !stl;
                pcw = is_st && rdy && !stl;
            end
            PH_W: begin
                rw   = !stl;
                pcw  = !stl;
                m2r  = is_ld;
                psrc = is_jmp ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
        return {pcw, irw, mr, mw, ms, rw, m2r, f[5], psrc, f[4:2], f[1:0], 3'(ph)};
    endfunction

    // Apply this cycle's inputs just after the falling edge, then let them settle
    task automatic drive(input logic rdy, input logic stl, input logic tkn);
        mem_ready    = rdy;
        stall        = stl;
        branch_taken = tkn;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        clock_edge();
        rst_n = 1'b1;
        exp_instret = '0;
    endtask

    task automatic test_reset();
        logic [17:0] got;
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            opcode = 7'($urandom);
            drive(rbit(), rbit(), rbit());
            got = act_vec();
            tests_run++;
            if (got !== 18'd0 || instret !== '0 || illegal_instr !== 1'b0 || mem_timeout !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_forced_zero: got vec=%b instret=%0d illegal=%b timeout=%b, expected all zero",
                         got, instret, illegal_instr, mem_timeout);
            end
            clock_edge();
        end
        rst_n       = 1'b1;
        exp_instret = '0;
        opcode      = OP_R;
        drive(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (state_o !== 3'd0 || instret !== '0 || illegal_instr !== 1'b0 || mem_timeout !== 1'b0
            || mem_read !== 1'b1 || mem_sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got state=%0d instret=%0d ill=%b to=%b mem_read=%b mem_sel=%b, expected 0 0 0 0 1 0",
                     state_o, instret, illegal_instr, mem_timeout, mem_read, mem_sel);
        end
    endtask

    task automatic test_add();
        logic [17:0] got;
        logic [17:0] want;
        int          expected_states [4] = '{0, 1, 2, 4};
        opcode = OP_R;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            got  = act_vec();
            want = exp_vec(expected_states[c], OP_R, 1'b0, 1'b0, 1'b1);
            tests_run++;
            if (got !== want || reg_write !== (c == 3)) begin
                tests_failed++;
                $display("FAIL add_cycle%0d: got %b expected %b", c, got, want);
            end
            clock_edge();
        end
        exp_instret++;
        tests_run++;
        if (state_o !== 3'd0 || instret !== exp_instret) begin
            tests_failed++;
            $display("FAIL add_retire: got state=%0d instret=%0d expected state=0 instret=%0d",
                     state_o, instret, exp_instret);
        end
    endtask

    task automatic test_load_wait();
        opcode = OP_LOAD;
        drive(1'b1, 1'b0, 1'b0);
        clock_edge();
        drive(1'b1, 1'b0, 1'b0);
        clock_edge();
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({state_o, alu_src, imm_type, alu_op} !== {3'd2, 1'b1, 3'd0, 2'b00}) begin
            tests_failed++;
            $display("FAIL load_execute: got state=%0d alu_src=%b imm=%b alu_op=%b expected 2 1 000 00",
                     state_o, alu_src, imm_type, alu_op);
        end
        clock_edge();
        for (int k = 0; k < 4; k++) begin
            drive(k == 3, 1'b0, 1'b0);
            tests_run++;
            if ({state_o, mem_read, mem_sel, mem_write, reg_write} !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL load_mem_wait%0d: got state=%0d rd=%b sel=%b wr=%b rw=%b expected 3 1 1 0 0",
                         k, state_o, mem_read, mem_sel, mem_write, reg_write);
            end
            clock_edge();
        end
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({state_o, reg_write, mem_to_reg, pc_write, pc_src} !== {3'd4, 1'b1, 1'b1, 1'b1, 2'b00}) begin
            tests_failed++;
            $display("FAIL load_wb: got state=%0d rw=%b m2r=%b pcw=%b pc_src=%b expected 4 1 1 1 00",
                     state_o, reg_write, mem_to_reg, pc_write, pc_src);
        end
        clock_edge();
        exp_instret++;
        tests_run++;
        if (state_o !== 3'd0 || instret !== exp_instret) begin
            tests_failed++;
            $display("FAIL load_retire_8cyc: got state=%0d instret=%0d expected 0 %0d",
                     state_o, instret, exp_instret);
        end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            opcode = OP_BRANCH;
            drive(1'b1, 1'b0, 1'b0);
            clock_edge();
            drive(1'b1, 1'b0, 1'b0);
            clock_edge();
            drive(1'b1, 1'b0, t == 1);
            tests_run++;
            if ({state_o, pc_write, pc_src, alu_op, imm_type} !== {3'd2, 1'b1, (t == 1) ? 2'b01 : 2'b00, 2'b01, 3'd2}) begin
                tests_failed++;
                $display("FAIL branch_execute_taken%0d: got state=%0d pcw=%b pc_src=%b alu_op=%b imm=%b",
                         t, state_o, pc_write, pc_src, alu_op, imm_type);
            end
            clock_edge();
            exp_instret++;
            tests_run++;
            if (state_o !== 3'd0 || instret !== exp_instret) begin
                tests_failed++;
                $display("FAIL branch_retire_taken%0d: got state=%0d instret=%0d expected 0 %0d",
                         t, state_o, instret, exp_instret);
            end
        end
    endtask

    task automatic test_stall_jal();
        opcode = OP_JAL;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            clock_edge();
        end
        for (int s = 0; s < 5; s++) begin
            drive(rbit(), 1'b1, rbit());
            tests_run++;
            if ({state_o, reg_write, pc_write, pc_src} !== {3'd4, 1'b0, 1'b0, 2'b10} || instret !== exp_instret) begin
                tests_failed++;
                $display("FAIL jal_stall%0d: got state=%0d rw=%b pcw=%b pc_src=%b instret=%0d expected 4 0 0 10 %0d",
                         s, state_o, reg_write, pc_write, pc_src, instret, exp_instret);
            end
            clock_edge();
        end
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({state_o, reg_write, pc_write, pc_src, mem_to_reg} !== {3'd4, 1'b1, 1'b1, 2'b10, 1'b0}) begin
            tests_failed++;
            $display("FAIL jal_release: got state=%0d rw=%b pcw=%b pc_src=%b m2r=%b expected 4 1 1 10 0",
                     state_o, reg_write, pc_write, pc_src, mem_to_reg);
        end
        clock_edge();
        exp_instret++;
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (state_o !== 3'd0 || instret !== exp_instret) begin
            tests_failed++;
            $display("FAIL jal_retire_once: got state=%0d instret=%0d expected 0 %0d",
                     state_o, instret, exp_instret);
        end
    endtask

    task automatic test_timeout();
        opcode = OP_R;
        for (int i = 0; i < MAX_WAIT_TB; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            tests_run++;
            if (state_o !== 3'd0 || ir_write !== 1'b0 || mem_read !== 1'b1 || mem_timeout !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_wait%0d: got state=%0d irw=%b rd=%b to=%b expected 0 0 1 0",
                         i, state_o, ir_write, mem_read, mem_timeout);
            end
            clock_edge();
        end
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (act_vec() !== {15'd0, 3'd5} || mem_timeout !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_trap: got vec=%b to=%b expected vec=%b to=1",
                     act_vec(), mem_timeout, {15'd0, 3'd5});
        end
        do_reset();
        for (int i = 0; i < MAX_WAIT_TB; i++) begin
            drive(i == MAX_WAIT_TB - 1, 1'b0, 1'b0);
            clock_edge();
        end
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (state_o !== 3'd1 || mem_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_ready_wins: got state=%0d to=%b expected 1 0", state_o, mem_timeout);
        end
        for (int c = 0; c < 3; c++) begin
            clock_edge();
        end
        exp_instret++;
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (state_o !== 3'd0 || instret !== exp_instret) begin
            tests_failed++;
            $display("FAIL timeout_ready_retire: got state=%0d instret=%0d expected 0 %0d",
                     state_o, instret, exp_instret);
        end
    endtask

    task automatic test_illegal();
        opcode = 7'b1111111;
        drive(1'b1, 1'b0, 1'b0);
        clock_edge();
        drive(1'b1, 1'b0, 1'b0);
        clock_edge();
        for (int c = 0; c < 20; c++) begin
            opcode = 7'($urandom);
            drive(rbit(), rbit(), rbit());
            tests_run++;
            if (act_vec() !== {15'd0, 3'd5} || illegal_instr !== 1'b1) begin
                tests_failed++;
                $display("FAIL illegal_trap%0d: got vec=%b ill=%b expected vec=%b ill=1",
                         c, act_vec(), illegal_instr, {15'd0, 3'd5});
            end
            clock_edge();
        end
        do_reset();
        opcode = OP_R;
        drive(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (state_o !== 3'd0 || illegal_instr !== 1'b0 || instret !== '0) begin
            tests_failed++;
            $display("FAIL illegal_cleared: got state=%0d ill=%b instret=%0d expected 0 0 0",
                     state_o, illegal_instr, instret);
        end
    endtask

    task automatic test_reset_mid();
        opcode = OP_STORE;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            clock_edge();
        end
        drive(1'b0, 1'b0, 1'b0);
        tests_run++;
        if ({state_o, mem_write, mem_sel, alu_src} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL store_mem: got state=%0d wr=%b sel=%b alu_src=%b expected 3 1 1 0",
                     state_o, mem_write, mem_sel, alu_src);
        end
        clock_edge();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (act_vec() !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %b expected all zero", act_vec());
        end
        clock_edge();
        rst_n       = 1'b1;
        exp_instret = '0;
        drive(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (state_o !== 3'd0 || instret !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_abandon: got state=%0d instret=%0d expected 0 0", state_o, instret);
        end
    endtask

    // Random instruction stream: each instruction is a list of phases; a
    // phase advances on a non-stalled cycle, memory phases also need ready.
    task automatic test_random(input int n_instr);
        logic [6:0]  op;
        int          phases [$];
        int          idx;
        int          waits;
        int          guard;
        logic        stl;
        logic        rdy;
        logic        tkn;
        logic [17:0] want;
        for (int k = 0; k < n_instr; k++) begin
            op     = LEGAL_OPS[$urandom_range(8, 0)];
            phases = {PH_F, PH_D, PH_E};
            if (op == OP_LOAD) begin
                phases.push_back(PH_M);
                phases.push_back(PH_W);
            end else if (op == OP_STORE) begin
                phases.push_back(PH_M);
            end else if (op != OP_BRANCH) begin
                phases.push_back(PH_W);
            end
            opcode = op;
            idx    = 0;
            waits  = 0;
            guard  = 0;
            while (idx < phases.size() && guard < 200) begin
                stl = ($urandom_range(4, 0) == 0);
                rdy = ($urandom_range(9, 0) < 6) || (waits == MAX_WAIT_TB - 1);
                tkn = rbit();
                drive(rdy, stl, tkn);
                want = exp_vec(phases[idx], op, tkn, stl, rdy);
                tests_run++;
                if (act_vec() !== want || instret !== exp_instret || mem_timeout !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL random_cycle i%0d op=%b ph=%0d: got %b instret=%0d to=%b expected %b instret=%0d to=0",
                             k, op, phases[idx], act_vec(), instret, mem_timeout, want, exp_instret);
                end
                clock_edge();
                guard++;
                if (!stl) begin
                    if ((phases[idx] == PH_F || phases[idx] == PH_M) && !rdy) begin
                        waits++;
                    end else begin
                        idx++;
                        waits = 0;
                    end
                end
            end
            exp_instret++;
            drive(1'b0, 1'b0, 1'b0);
            tests_run++;
            if (guard >= 200 || state_o !== 3'd0 || instret !== exp_instret) begin
                tests_failed++;
                $display("FAIL random_retire i%0d op=%b: got state=%0d instret=%0d expected 0 %0d",
                         k, op, state_o, instret, exp_instret);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        opcode       = '0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        stall        = 1'b0;
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_stall_jal();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random(40);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- FSM-based control unit for the multi-cycle RV32I datapath; successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB over shared memory with a ready handshake.
- Adds stall support, a memory-wait timeout, illegal-opcode trapping and a retired-instruction counter.
- Sits between instruction register/memory interface and datapath muxes/write enables.

Parameters:
- MAX_WAIT, 16, cycles a FETCH/MEM access may wait for mem_ready before trapping (1..255).
- INSTRET_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  7  instruction[6:0] from instruction register.
- branch_taken  in  1  ALU compare result, valid in EXECUTE.
- mem_ready  in  1  memory completes current access this cycle.
- stall  in  1  freeze request.
- pc_write  out  1  PC register load enable.
- ir_write  out  1  instruction register load enable.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_sel  out  1  0 = PC addresses memory, 1 = ALU result.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback selects memory data.
- alu_src  out  1  0 = rs2, 1 = immediate.
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = JAL/JALR target.
- imm_type  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- alu_op  out  2  00 = add/pass, 01 = branch compare, 10 = R-type, 11 = I-type.
- state_o  out  3  current state, for debug.
- illegal_instr  out  1  sticky: unknown opcode decoded.
- mem_timeout  out  1  sticky: wait exceeded MAX_WAIT.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- States: FETCH = 0, DECODE = 1, EXECUTE = 2, MEM = 3, WB = 4, TRAP = 5.
- Reset:
  - When rst_n = 0 at a clk edge: state = FETCH; opcode_q, wait counter, instret and sticky flags = 0.
  - While rst_n is low, all outputs are forced to 0.
  - Reset mid-instruction abandons it; nothing is written.
- FETCH:
  - mem_read = 1, mem_sel = 0.
  - On mem_ready: ir_write = 1, go to DECODE.
- DECODE:
  - Latch opcode into opcode_q.
  - Unknown opcode: go to TRAP, set illegal_instr.
  - Known opcode: go to EXECUTE.
- EXECUTE: alu_src, alu_op and imm_type are driven from opcode_q, with the same static encoding as the single-cycle decoder.
  - BRANCH: pc_write = 1; pc_src = 01 if branch_taken, else 00. Retire, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All other opcodes: go to WB.
- MEM:
  - mem_sel = 1; mem_read (LOAD) or mem_write (STORE); held until mem_ready.
  - LOAD + mem_ready: go to WB.
  - STORE + mem_ready: pc_write = 1, pc_src = 00. Retire, go to FETCH.
- WB:
  - reg_write = 1; mem_to_reg = 1 for LOAD only.
  - pc_write = 1; pc_src = 10 for JAL/JALR, else 00.
  - Retire, go to FETCH.
- Retire: instret increments by 1 and wraps modulo 2^INSTRET_W.
- TRAP:
  - Absorbing state: every enable/request output is 0.
  - Exit only via reset.
- Latency with mem_ready tied high (cycles per instruction):
  - Branch: 3.
  - R, I, JAL, JALR, LUI, AUIPC: 4.
  - Store: 4.
  - Load: 5.
- Wait counter:
  - Counts cycles spent in FETCH/MEM with mem_ready = 0; cleared on state change.
  - Reaching MAX_WAIT with mem_ready still 0: go to TRAP, set mem_timeout.
  - mem_ready asserted in the same cycle the counter reaches MAX_WAIT wins: normal transition, no trap.
- Stall:
  - stall = 1 freezes state, opcode_q and the wait counter.
  - Forces pc_write, ir_write, reg_write, mem_write, mem_read = 0.
  - mem_ready is ignored during stall.
  - Reset has priority over stall.
- All outputs are combinational from state, opcode_q, branch_taken, mem_ready and stall. No output is registered except instret, flags and state_o.

Decomposition:
- ctrl_pkg holds:
  - Opcode constants: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - State encoding.
  - imm_type, pc_src and alu_op codes.
- One natural sub-module: opcode_field_decode.
  - Combinational map opcode_q -> {alu_src, imm_type, alu_op, is_load, is_store, is_branch, is_jump, legal}.
  - The FSM gates these fields by state.

Test Plan:
- Reset, then ADD (0110011) with mem_ready = 1 → states 0,1,2,4; reg_write = 1 only in WB; instret = 1 after 4 cycles.
- LW (0000011), mem_ready low 3 cycles in MEM → mem_read and mem_sel = 1 held 4 cycles; WB has mem_to_reg = 1; total 8 cycles.
- BEQ (1100011):
  - branch_taken = 1 → pc_src = 01, pc_write = 1 in EXECUTE; back to FETCH after 3 cycles.
  - Repeat with branch_taken = 0 → pc_src = 00.
- Opcode 7'b1111111 → TRAP after DECODE, illegal_instr = 1, all strobes 0 for 20 cycles; rst_n = 0 one cycle → state 0, flag cleared.
- mem_ready held 0 in FETCH with MAX_WAIT = 4 → TRAP and mem_timeout = 1. Separately, mem_ready on the 4th waiting cycle → DECODE, no trap.
- stall = 1 for 5 cycles mid-WB of JAL → no reg_write or pc_write during stall. On release WB completes with pc_src = 10 and instret increments exactly once.
